// File: rtl/mtcmos_retention_reg.sv
// ---------------------------------------------------------------------------
// mtcmos_retention_reg
//   WIDTH-bit MTCMOS state-retention register. Keeps its value across a full
//   power-down of the gated domain and sequences the header switch, the output
//   isolation and retention save/restore with a registered FSM:
//     ACTIVE -> SAVE -> OFF -> WAKE (WAKE_CYCLES) -> RESTORE -> ACTIVE
//
// Ports
//   clk        always-on clock, all state updates on posedge
//   rst        asynchronous, active-high reset
//   d          data input
//   en         load enable, honoured only in ACTIVE
//   sleep_req  level request from the power controller to power down
//   q          isolated output: ISO_VAL while iso_en=1, else main register
//   sleep_ack  1 while in OFF (rail gated, value retained)
//   pwr_en     header-switch enable, 0 only in OFF
//   iso_en     output isolation, 1 in SAVE, OFF, WAKE and RESTORE
//   ready      1 only in ACTIVE
//   sleep_cnt  saturating count of completed sleep cycles (SLEEP_CNT_EN only)
//
// Configuration macro
//   SLEEP_CNT_EN  adds the 16-bit sleep_cnt port and its counter
// ---------------------------------------------------------------------------
module mtcmos_retention_reg #(
    parameter int                 WIDTH       = 8,
    parameter int                 WAKE_CYCLES = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL   = '0,
    parameter logic [WIDTH-1:0]   ISO_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             sleep_req,
    output logic [WIDTH-1:0] q,
    output logic             sleep_ack,
    output logic             pwr_en,
    output logic             iso_en,
    output logic             ready
`ifdef SLEEP_CNT_EN
    ,
    output logic [15:0]      sleep_cnt
`endif
);

    localparam int CNT_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_SAVE,
        ST_OFF,
        ST_WAKE,
        ST_RESTORE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   ret_q, ret_d;
    logic [CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic               pwr_en_q, iso_en_q, sleep_ack_q, ready_q;

    // Next-state and datapath decode.
    // NOTE: every variable gets a hold default before the case so no path
    // leaves one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        ret_d      = ret_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            ST_ACTIVE: begin
                // Load and sleep together: the load lands first and is the
                // value captured in SAVE on the following edge.
                if (en) main_d = d;
                if (sleep_req) state_d = ST_SAVE;
            end
            ST_SAVE: begin
                ret_d   = main_q;
                main_d  = '0;          // gated state is lost once the rail drops
                state_d = ST_OFF;      // unconditional: OFF lasts at least one cycle
            end
            ST_OFF: begin
                if (!sleep_req) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) state_d = ST_RESTORE;
                else                         wake_cnt_d = wake_cnt_q + CNT_W'(1);
            end
            ST_RESTORE: begin
                main_d  = ret_q;
                state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // State, data and control registers. Control outputs are decoded from the
    // next state so they change on the same edge as the state itself.
    // NOTE: the retention register sits in the reset branch like the rest of
    // the state; it is a plain register, and reset is defined to discard the
    // retained value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACTIVE;
            main_q      <= RESET_VAL;
            ret_q       <= RESET_VAL;
            wake_cnt_q  <= '0;
            pwr_en_q    <= 1'b1;
            iso_en_q    <= 1'b0;
            sleep_ack_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            main_q      <= main_d;
            ret_q       <= ret_d;
            wake_cnt_q  <= wake_cnt_d;
            pwr_en_q    <= (state_d != ST_OFF);
            iso_en_q    <= (state_d != ST_ACTIVE);
            sleep_ack_q <= (state_d == ST_OFF);
            ready_q     <= (state_d == ST_ACTIVE);
        end
    end

`ifdef SLEEP_CNT_EN
    logic [15:0] sleep_cnt_q;

    // One count per RESTORE->ACTIVE transition, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sleep_cnt_q <= '0;
        end else if (state_q == ST_RESTORE && sleep_cnt_q != 16'hFFFF) begin
            sleep_cnt_q <= sleep_cnt_q + 16'd1;
        end
    end

    assign sleep_cnt = sleep_cnt_q;
`endif

    // Isolation clamp: the cleared main register is never visible.
    assign q         = iso_en_q ? ISO_VAL : main_q;
    assign pwr_en    = pwr_en_q;
    assign iso_en    = iso_en_q;
    assign sleep_ack = sleep_ack_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_mtcmos_retention_reg.sv
// ---------------------------------------------------------------------------
// tb_mtcmos_retention_reg
//   Scoreboard bench for mtcmos_retention_reg. Directed vectors are applied on
//   the falling edge; each vector pushes the hand-computed output expected
//   after the next rising edge. A separate monitor pops and compares entries
//   1 time unit after each rising edge (or immediately, for async reset).
//   Control outputs are compared as {pwr_en, iso_en, sleep_ack, ready}.
//   Build with +define+SLEEP_CNT_EN to also cover the sleep counter.
// ---------------------------------------------------------------------------
module tb_mtcmos_retention_reg;

    localparam int          WIDTH = 8;
    localparam int          WAKE  = 4;
    localparam logic [7:0]  RVAL  = 8'h11;
    localparam logic [7:0]  IVAL  = 8'hFF;

    // {pwr_en, iso_en, sleep_ack, ready}
    localparam logic [3:0] C_ACT = 4'b1001;  // ACTIVE
    localparam logic [3:0] C_ISO = 4'b1100;  // SAVE, WAKE, RESTORE
    localparam logic [3:0] C_OFF = 4'b0110;  // OFF

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             sleep_req;
    logic [WIDTH-1:0] q;
    logic             sleep_ack;
    logic             pwr_en;
    logic             iso_en;
    logic             ready;
`ifdef SLEEP_CNT_EN
    logic [15:0]      sleep_cnt;
`endif

    mtcmos_retention_reg #(
        .WIDTH       (WIDTH),
        .WAKE_CYCLES (WAKE),
        .RESET_VAL   (RVAL),
        .ISO_VAL     (IVAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .en        (en),
        .sleep_req (sleep_req),
        .q         (q),
        .sleep_ack (sleep_ack),
        .pwr_en    (pwr_en),
        .iso_en    (iso_en),
        .ready     (ready)
`ifdef SLEEP_CNT_EN
        ,
        .sleep_cnt (sleep_cnt)
`endif
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [7:0]  q;
        logic [3:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc_cnt  = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = 16'd0;
    event        chk_ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and sampling strobe 1 unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt <= cyc_cnt + 1;
            #1;
            -> chk_ev;
        end
    end

    // Monitor: compare every entry whose cycle has been reached.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(chk_ev);
            while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
                e = sb.pop_front();
                checks++;
                ok = (q === e.q) && ({pwr_en, iso_en, sleep_ack, ready} === e.ctl);
`ifdef SLEEP_CNT_EN
                ok = ok && (sleep_cnt === e.cnt);
`endif
                if (!ok) begin
                    failures++;
`ifdef SLEEP_CNT_EN
                    $display("FAIL %s @cyc %0d: got q=%h ctl=%b cnt=%h, expected q=%h ctl=%b cnt=%h",
                             e.name, cyc_cnt, q, {pwr_en, iso_en, sleep_ack, ready}, sleep_cnt,
                             e.q, e.ctl, e.cnt);
`else
                    $display("FAIL %s @cyc %0d: got q=%h ctl=%b, expected q=%h ctl=%b",
                             e.name, cyc_cnt, q, {pwr_en, iso_en, sleep_ack, ready}, e.q, e.ctl);
`endif
                end
            end
        end
    end

    // Drive one vector on the falling edge; expectation is for after the next rise.
    task automatic vec(input logic e_i, input logic [7:0] d_i, input logic sr_i,
                       input logic [7:0] eq, input logic [3:0] ectl, input string nm);
        exp_t x;
        @(negedge clk);
        en        = e_i;
        d         = d_i;
        sleep_req = sr_i;
        x.cyc  = cyc_cnt + 1;
        x.name = nm;
        x.q    = eq;
        x.ctl  = ectl;
        x.cnt  = exp_cnt;
        sb.push_back(x);
    endtask

    // Expectation checked immediately (asynchronous effects).
    task automatic check_now(input logic [7:0] eq, input logic [3:0] ectl, input string nm);
        exp_t x;
        x.cyc  = cyc_cnt;
        x.name = nm;
        x.q    = eq;
        x.ctl  = ectl;
        x.cnt  = exp_cnt;
        sb.push_back(x);
        #1;
        -> chk_ev;
    endtask

    // sleep_req high for SAVE plus off_n OFF cycles, then a full wake-up.
    task automatic full_sleep(input int off_n, input logic [7:0] q_after,
                              input logic [15:0] cnt_after, input string nm);
        vec(1'b0, 8'h00, 1'b1, IVAL, C_ISO, {nm, "_save"});
        for (int i = 0; i < off_n; i++) vec(1'b0, 8'h00, 1'b1, IVAL, C_OFF, {nm, "_off"});
        for (int i = 0; i < WAKE; i++)  vec(1'b0, 8'h00, 1'b0, IVAL, C_ISO, {nm, "_wake"});
        vec(1'b0, 8'h00, 1'b0, IVAL, C_ISO, {nm, "_restore"});
        exp_cnt = cnt_after;
        vec(1'b0, 8'h00, 1'b0, q_after, C_ACT, {nm, "_active"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        d         = '0;
        sleep_req = 1'b0;
        #2;
        check_now(RVAL, C_ACT, "reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Load and hold
        vec(1'b0, 8'h00, 1'b0, RVAL,  C_ACT, "post_reset");
        vec(1'b1, 8'hA5, 1'b0, 8'hA5, C_ACT, "load");
        vec(1'b0, 8'h3C, 1'b0, 8'hA5, C_ACT, "hold");

        // Full cycle: sleep_req high 10 cycles, ack two cycles after first high
        full_sleep(9, 8'hA5, 16'd1, "full");

        // Load and sleep on the same edge: load wins, then it is retained
        vec(1'b1, 8'h5A, 1'b1, IVAL, C_ISO, "simul_save");
        vec(1'b0, 8'h00, 1'b1, IVAL, C_OFF, "simul_off");
        for (int i = 0; i < WAKE; i++) vec(1'b0, 8'h00, 1'b0, IVAL, C_ISO, "simul_wake");
        vec(1'b0, 8'h00, 1'b0, IVAL, C_ISO, "simul_restore");
        exp_cnt = 16'd2;
        vec(1'b0, 8'h00, 1'b0, 8'h5A, C_ACT, "simul_active");

        // One-cycle pulse: OFF for one cycle; en/d and sleep_req ignored until ACTIVE
        vec(1'b0, 8'h00, 1'b1, IVAL, C_ISO, "pulse_save");
        vec(1'b1, 8'hC3, 1'b0, IVAL, C_OFF, "pulse_off");
        vec(1'b1, 8'hC3, 1'b0, IVAL, C_ISO, "pulse_wake0");
        vec(1'b1, 8'hC3, 1'b1, IVAL, C_ISO, "pulse_wake1");
        vec(1'b1, 8'hC3, 1'b1, IVAL, C_ISO, "pulse_wake2");
        vec(1'b1, 8'hC3, 1'b1, IVAL, C_ISO, "pulse_wake3");
        vec(1'b1, 8'hC3, 1'b1, IVAL, C_ISO, "pulse_restore");
        exp_cnt = 16'd3;
        vec(1'b1, 8'hC3, 1'b1, 8'h5A, C_ACT, "pulse_active");
        vec(1'b0, 8'h00, 1'b0, 8'h5A, C_ACT, "pulse_stay");
        vec(1'b1, 8'h96, 1'b0, 8'h96, C_ACT, "reload");

        // Async reset in the middle of WAKE
        vec(1'b0, 8'h00, 1'b1, IVAL, C_ISO, "rst_save");
        vec(1'b0, 8'h00, 1'b0, IVAL, C_OFF, "rst_off");
        vec(1'b0, 8'h00, 1'b0, IVAL, C_ISO, "rst_wake0");
        vec(1'b0, 8'h00, 1'b0, IVAL, C_ISO, "rst_wake1");
        @(negedge clk);
        rst     = 1'b1;
        exp_cnt = 16'd0;
        check_now(RVAL, C_ACT, "async_reset");
        @(negedge clk);
        rst = 1'b0;
        vec(1'b0, 8'h00, 1'b0, RVAL, C_ACT, "after_reset");

        // Retained value was discarded by reset
        full_sleep(1, RVAL, 16'd1, "ret_lost");

`ifdef SLEEP_CNT_EN
        // Saturation at all-ones
        @(negedge clk);
        force dut.sleep_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.sleep_cnt_q;
        exp_cnt = 16'hFFFF;
        vec(1'b0, 8'h00, 1'b0, RVAL, C_ACT, "preload");
        full_sleep(2, RVAL, 16'hFFFF, "saturate");
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
